lcd_timing_generator: RTL
=========================

# lcd_timing_generator

Generates the RGB-LCD raster for the 480×272 panel. It divides the system clock into `lcd_dclk` and produces `lcd_hsync`, `lcd_vsync` and `lcd_de`. It also drives the `pos_x`/`pos_y` coordinates consumed by the downstream character-cell pixel generator. `lcd_dclk` phase is placed so that the generator's 4-clk pixel pipeline settles before every panel sampling (rising) edge.

## Interface
Parameters:
- `H_ACTIVE`, 480: visible pixels per line.
- `H_FP`, 2: horizontal front porch, in dclk cycles.
- `H_SYNC`, 41: hsync width, in dclk cycles.
- `H_BP`, 2: horizontal back porch, in dclk cycles.
- `V_ACTIVE`, 272: visible lines.
- `V_FP`, 2: vertical front porch, in lines.
- `V_SYNC`, 10: vsync width, in lines.
- `V_BP`, 2: vertical back porch, in lines.
- `CLK_DIV`, 10: clk cycles per dclk period. Must be even, and `CLK_DIV/2 > PIPE_LAT`.
- `PIPE_LAT`, 4: downstream pixel latency in clk. Used only for the legality check.
- Under `SIM`: `H_ACTIVE`=64, `V_ACTIVE`=32, all porches and syncs = 2.

Ports:
- Reset is asynchronous and active-high.
- `clk`  in  1: system clock, the same clock as the pixel generator.
- `rst`  in  1: asynchronous, active-high reset.
- `pos_x`  out  10: active column; 0 outside the horizontal active region.
- `pos_y`  out  9: active line; 0 outside the vertical active region.
- `lcd_dclk`  out  1: panel pixel clock; the panel samples on its rising edge.
- `lcd_hsync`  out  1: active-low horizontal sync.
- `lcd_vsync`  out  1: active-low vertical sync.
- `lcd_de`  out  1: data enable; high when both horizontal and vertical are active.
- `frame_start`  out  1: one-clk pulse when the raster enters (h=0, v=0).

## Operation
- Derived totals: `H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP` (must be ≤1024) and `V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP` (must be ≤512).
- Three counters:
  - `div_cnt`: 0..`CLK_DIV`-1, increments every clk.
  - `h_cnt`: 0..`H_TOTAL`-1, advances when `div_cnt` wraps to 0.
  - `v_cnt`: 0..`V_TOTAL`-1, advances when `h_cnt` wraps to 0.
- Line region order: active [0, `H_ACTIVE`), front porch, sync, back porch. Frame order is the same, using `v_cnt`.
- `lcd_hsync` = 0 iff `h_cnt` ∈ [`H_ACTIVE+H_FP`, `H_ACTIVE+H_FP+H_SYNC`). `lcd_vsync` is the same rule on `v_cnt`.
- `lcd_de` = (`h_cnt` < `H_ACTIVE`) && (`v_cnt` < `V_ACTIVE`).
- `pos_x` = `h_cnt` if horizontally active, else 0. `pos_y` = `v_cnt` if vertically active, else 0.
- All outputs are registered. They are computed from the next counter values so that each output changes on the same clk edge as its counter.
- `lcd_dclk` is 1 while `div_cnt` ∈ [`CLK_DIV/2`, `CLK_DIV`-1], otherwise 0, and is registered alongside `div_cnt`.
- `frame_start` = 1 for exactly the one clk in which `div_cnt`=0, `h_cnt`=0 and `v_cnt`=0 were just entered.

## Timing
- Reset state: `div_cnt`=`CLK_DIV`-1, `h_cnt`=`H_TOTAL`-1, `v_cnt`=`V_TOTAL`-1.
- Output values during reset: `pos_x`=0, `pos_y`=0, `lcd_dclk`=1, `lcd_hsync`=1, `lcd_vsync`=1, `lcd_de`=0, `frame_start`=0.
- First clk edge after reset release: all three counters wrap to 0. At that edge `frame_start`=1, `lcd_de`=1, `lcd_dclk` falls, and `pos` = (0,0).
- Within each dclk period, counting clk edges from the edge `E` where `div_cnt`→0:
  - E: `pos_x`, `pos_y`, `lcd_de`, `lcd_hsync` and `lcd_vsync` update, and `lcd_dclk` falls.
  - E+4: the downstream pixel becomes valid.
  - E+`CLK_DIV/2` (=E+5 by default): `lcd_dclk` rises. This gives ≥1 clk of setup, and the pixel stays stable until E+`CLK_DIV`+4.
- Wrap handling: `h_cnt` and `v_cnt` wrap on the same edge at the end of a frame, with no extra cycle inserted.
- Line period: `H_TOTAL`·`CLK_DIV` clk. Frame period: `V_TOTAL`·`H_TOTAL`·`CLK_DIV` clk.
- Reset asserted mid-line: all outputs go to their reset values immediately (asynchronously). The next frame restarts cleanly after release, with no partial sync pulse.

## Test plan
- Reset behaviour: hold `rst`=1 for 3 clk, then release. Required: reset values on every output during reset; on the first edge after release, `frame_start`=1, `lcd_de`=1, `pos`=(0,0), `lcd_dclk`=0.
- dclk shape: `lcd_dclk` period = 10 clk with 5 high and 5 low. `pos_x` changes only on `lcd_dclk` falling edges, and the rising edge comes exactly 5 clk after each `pos` change.
- Horizontal timing (default parameters): `lcd_de` high for 480 dclk per active line; `lcd_hsync` low for 41 dclk starting at dclk index 482; line = 525 dclk.
- Vertical timing: `lcd_vsync` low for 10 lines starting at line 274; frame = 286 lines; `frame_start` pulses every 1,501,500 clk.
- Blanking: during blanking, `pos_x`=0 and `pos_y`=0. Within an active line, `pos_x` sequence is 0, 1, …, 479. The last active pixel is `pos` = (479, 271).
- SIM build plus mid-frame reset: with the `SIM` parameters, line = 70 dclk and frame = 38 lines. Asserting `rst` in line 10 forces reset values immediately; after release, `frame_start` is seen on the first edge.

Source files
------------

// File: rtl/lcd_timing_generator.sv
// lcd_timing_generator
// Produces the RGB-LCD raster (pixel clock, syncs, data enable) and the
// active-region pixel coordinates for the character-cell pixel generator.
//
// Ports:
//   clk         in   1  system clock, shared with the pixel generator
//   rst         in   1  asynchronous, active-high reset
//   pos_x       out 10  active column, 0 outside the horizontal active region
//   pos_y       out  9  active line, 0 outside the vertical active region
//   lcd_dclk    out  1  panel pixel clock, panel samples on its rising edge
//   lcd_hsync   out  1  active-low horizontal sync
//   lcd_vsync   out  1  active-low vertical sync
//   lcd_de      out  1  data enable (horizontally and vertically active)
//   frame_start out  1  one-clk pulse when the raster enters (h=0, v=0)
//
// Every output is a flop loaded from the *next* counter values, so each output
// moves on the same clk edge as the counter it is derived from. lcd_dclk falls
// on the edge where div_cnt returns to 0 (the same edge pos_x/pos_y move) and
// rises CLK_DIV/2 clks later, leaving the downstream PIPE_LAT-clk pipeline time
// to settle before the panel samples.
module lcd_timing_generator #(
`ifdef SIM
    parameter int H_ACTIVE = 64,
    parameter int H_FP     = 2,
    parameter int H_SYNC   = 2,
    parameter int H_BP     = 2,
    parameter int V_ACTIVE = 32,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 2,
`else
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 2,
    parameter int H_SYNC   = 41,
    parameter int H_BP     = 2,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 10,
    parameter int V_BP     = 2,
`endif
    parameter int CLK_DIV  = 10,
    parameter int PIPE_LAT = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] pos_x,
    output logic [8:0] pos_y,
    output logic       lcd_dclk,
    output logic       lcd_hsync,
    output logic       lcd_vsync,
    output logic       lcd_de,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = $clog2(CLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [8:0] V_LAST     = 9'(V_TOTAL - 1);
    localparam logic [8:0] V_ACT_END  = 9'(V_ACTIVE);
    localparam logic [8:0] VS_START   = 9'(V_ACTIVE + V_FP);
    localparam logic [8:0] VS_END     = 9'(V_ACTIVE + V_FP + V_SYNC);

    // Reject parameter sets the counters or the pixel pipeline cannot support.
    generate
        if ((CLK_DIV % 2 != 0) || (CLK_DIV / 2 <= PIPE_LAT) ||
            (H_TOTAL > 1024) || (V_TOTAL > 512)) begin : g_bad_cfg
            $error("lcd_timing_generator: illegal timing parameters");
        end
    endgenerate

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]    h_cnt_q, h_cnt_d;
    logic [8:0]    v_cnt_q, v_cnt_d;
    logic [9:0]    pos_x_q, pos_x_d;
    logic [8:0]    pos_y_q, pos_y_d;
    logic          dclk_q, dclk_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic          frame_start_q, frame_start_d;
    logic          div_wrap_s, h_wrap_s, v_wrap_s;
    logic          h_act_s, v_act_s;

    // Next counter values and the outputs derived from them.
    always_comb begin
        div_cnt_d     = div_cnt_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        div_wrap_s    = (div_cnt_q == DIV_LAST);
        h_wrap_s      = div_wrap_s && (h_cnt_q == H_LAST);
        v_wrap_s      = h_wrap_s && (v_cnt_q == V_LAST);

        if (div_wrap_s) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + DIV_ONE;
        end

        if (h_wrap_s) begin
            h_cnt_d = '0;
        end else if (div_wrap_s) begin
            h_cnt_d = h_cnt_q + 10'd1;
        end else begin
            h_cnt_d = h_cnt_q;
        end

        if (v_wrap_s) begin
            v_cnt_d = '0;
        end else if (h_wrap_s) begin
            v_cnt_d = v_cnt_q + 9'd1;
        end else begin
            v_cnt_d = v_cnt_q;
        end

        h_act_s       = (h_cnt_d < H_ACT_END);
        v_act_s       = (v_cnt_d < V_ACT_END);
        pos_x_d       = h_act_s ? h_cnt_d : 10'd0;
        pos_y_d       = v_act_s ? v_cnt_d : 9'd0;
        de_d          = h_act_s && v_act_s;
        hsync_d       = !((h_cnt_d >= HS_START) && (h_cnt_d < HS_END));
        vsync_d       = !((v_cnt_d >= VS_START) && (v_cnt_d < VS_END));
        dclk_d        = (div_cnt_d >= DIV_HALF);
        frame_start_d = v_wrap_s;
    end

    // Counter and output registers; reset parks the counters on their last
    // value so the first edge after release enters (0,0) with frame_start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q     <= DIV_LAST;
            h_cnt_q       <= H_LAST;
            v_cnt_q       <= V_LAST;
            pos_x_q       <= 10'd0;
            pos_y_q       <= 9'd0;
            dclk_q        <= 1'b1;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            de_q          <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            pos_x_q       <= pos_x_d;
            pos_y_q       <= pos_y_d;
            dclk_q        <= dclk_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pos_x       = pos_x_q;
    assign pos_y       = pos_y_q;
    assign lcd_dclk    = dclk_q;
    assign lcd_hsync   = hsync_q;
    assign lcd_vsync   = vsync_q;
    assign lcd_de      = de_q;
    assign frame_start = frame_start_q;

endmodule
